ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares one simple dual-port RAM (one write port, one read port, common clock) between `NUM_REQ` requesters.
- Write and read ports are arbitrated independently, each with a round-robin grant.
- Granted commands are registered onto the RAM pins.
- Read data is routed back to the requester that issued the read, using a tag pipeline matched to the RAM read latency.
- Sits between client blocks (DMA, CPU-side port) and the `ram` instance.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `RAM_WIDTH`, 8: data width.
- `ADDR_WIDTH`, 9: address width (RAM depth 512).
- `RD_LAT`, 1: RAM cycles from `ram_rd_en` to valid `ram_rd_data` (1..4).

Ports:
- `clk`  in  1  single clock; also drives RAM `wr_clk`/`rd_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  NUM_REQ  write request, one bit per requester.
- `wr_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i in slice i.
- `wr_data_i`  in  NUM_REQ*RAM_WIDTH  packed write data.
- `wr_gnt`  out  NUM_REQ  one-hot write grant, combinational.
- `rd_req`  in  NUM_REQ  read request.
- `rd_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- `rd_gnt`  out  NUM_REQ  one-hot read grant, combinational.
- `rd_valid`  out  NUM_REQ  one-hot; read data on `rd_data_o` belongs to this requester.
- `rd_data_o`  out  RAM_WIDTH  shared read-data return bus.
- `ram_wr_en`, `ram_wr_addr`, `ram_wr_data`  out  1/ADDR_WIDTH/RAM_WIDTH  to RAM write port, registered.
- `ram_rd_en`, `ram_rd_addr`  out  1/ADDR_WIDTH  to RAM read port, registered.
- `ram_rd_data`  in  RAM_WIDTH  from RAM.

## Operation

**Arbitration**
- Write and read arbiters are identical and fully independent. A write grant and a read grant to the same or different requesters may occur in the same cycle.
- Each arbiter keeps a pointer `ptr`, reset value 0. The highest-priority requester is `ptr`, then `ptr+1`, and so on, wrapping modulo `NUM_REQ`.
- On a grant to requester i, `ptr` becomes (i+1) mod `NUM_REQ`. With no request, `ptr` holds.
- Grant is combinational from the current `req` and `ptr`.
- A request is consumed at the rising edge where `req` & `gnt` are both high. A requester holds `req`, addr and data stable until granted. Back-to-back requests are allowed every cycle.

**Command and return path**
- Consumed write: the next edge loads `ram_wr_en`=1 with the granted address and data. Otherwise `ram_wr_en`=0 and address/data hold their previous value.
- Consumed read: `ram_rd_en`=1 and `ram_rd_addr`; the requester ID and a valid bit enter a `RD_LAT`-deep shift register.
- At the pipeline output: `rd_valid[id]`=1 for one cycle and `rd_data_o`=`ram_rd_data`. When not valid, `rd_data_o` holds its last value.

**Collisions**
- A same-cycle RAM write and read to the same address returns the RAM's native (old) data unless forwarding is enabled (see Configuration).

**Reset**
- All outputs are 0 at reset: grants, `rd_valid`, `rd_data_o`, and all `ram_*`.
- Both pointers are 0. The tag pipeline is cleared.
- Reads in flight at reset never produce `rd_valid`.

## Timing
- Cycle N: `req`&`gnt` high.
- Edge N→N+1: RAM command registered (`ram_*_en` high during N+1).
- Read: `rd_valid` high in cycle N+1+`RD_LAT` (N+2 for `RD_LAT`=1).
- Throughput: one write and one read per cycle sustained.
- All requesters requesting continuously: each is granted once every `NUM_REQ` cycles, in strict rotation.

## Configuration
Macro `RAM_ARB_FWD_EN`.
- **Defined:** in the cycle where `ram_wr_en` and `ram_rd_en` are both high with equal addresses, `ram_wr_data` is captured into a forward stage alongside the read tag. When that read returns, `rd_data_o` is the forwarded write data instead of `ram_rd_data`. Only same-issue-cycle collisions are forwarded.
- **Undefined:** no forward logic; `rd_data_o` is always `ram_rd_data`.

## Structure
- Package `ram_arb_pkg`: `ID_W` = `$clog2(NUM_REQ)` helper function, `rd_tag_t` struct (valid, id, and, under the macro, fwd_hit and fwd_data).
- One sub-module `rr_arbiter` (parameter `N`; ports `clk`, `rst_n`, `req`, `gnt`, `ptr` update on consume), instantiated twice: write and read.

## Test plan
- **Reset:** `rst_n` low mid-stream with reads in flight → all outputs 0; no `rd_valid` after release; first grant goes to requester 0.
- **Single write then read:** requester 0 writes addr 100 data 6; 2 cycles later requester 1 reads addr 100 → `rd_valid`=2'b10, `rd_data_o`=6 in cycle N+2 (`RD_LAT`=1).
- **Round-robin fairness:** `NUM_REQ`=4, all `wr_req` held high for 8 cycles → `wr_gnt` sequence 1,2,4,8,1,2,4,8; `ram_wr_addr` follows the granted slice.
- **Concurrent ports:** requester 0 writes addr 5 while requester 1 reads addr 7 (previously 0x33) in the same cycle → both granted; requester 1 gets 0x33.
- **Collision:** write 0xAA and read of addr 20 (old 0x11) issued the same cycle → returns 0x11 without `RAM_ARB_FWD_EN`, 0xAA with it.
- **Latency sweep:** `RD_LAT`=3, back-to-back reads by requesters 0,1,0 → `rd_valid` 1,2,1 in cycles N+4, N+5, N+6 with matching data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for ram_arbiter: read-tag layout and the id-width helper.
// Forward fields in rd_tag_t exist only when RAM_ARB_FWD_EN is defined.
package ram_arb_pkg;

    localparam int MAX_ID_W   = 3;   // covers NUM_REQ up to 8
    localparam int MAX_DATA_W = 64;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [MAX_ID_W-1:0]   id;
`ifdef RAM_ARB_FWD_EN
        logic                  fwd_hit;
        logic [MAX_DATA_W-1:0] fwd_data;
`endif
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at ptr; ptr moves
// past the winner on every grant and holds when nothing is requested.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = ID_W(N);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'((idx + 1) % N);
            end
        end
        // Grants are forced low while reset is asserted.
        if (!rst_n) gnt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a simple dual-port RAM between NUM_REQ requesters with independent
// round-robin write/read arbitration. RAM_ARB_FWD_EN forwards same-cycle W/R collisions.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LAT     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   wr_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [NUM_REQ-1:0][RAM_WIDTH-1:0]    wr_data_i,
    output logic [NUM_REQ-1:0]                   wr_gnt,
    input  logic [NUM_REQ-1:0]                   rd_req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_REQ-1:0]                   rd_gnt,
    output logic [NUM_REQ-1:0]                   rd_valid,
    output logic [RAM_WIDTH-1:0]                 rd_data_o,
    output logic                                 ram_wr_en,
    output logic [ADDR_WIDTH-1:0]                ram_wr_addr,
    output logic [RAM_WIDTH-1:0]                 ram_wr_data,
    output logic                                 ram_rd_en,
    output logic [ADDR_WIDTH-1:0]                ram_rd_addr,
    input  logic [RAM_WIDTH-1:0]                 ram_rd_data
);

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (.clk(clk), .rst_n(rst_n), .req(wr_req), .gnt(wr_gnt));
    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (.clk(clk), .rst_n(rst_n), .req(rd_req), .gnt(rd_gnt));

    logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
    logic [RAM_WIDTH-1:0]  wr_data_sel;
    logic [MAX_ID_W-1:0]   rd_id_sel;

    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        rd_id_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_addr_sel = wr_addr_i[i];
                wr_data_sel = wr_data_i[i];
            end
            if (rd_gnt[i]) begin
                rd_addr_sel = rd_addr_i[i];
                rd_id_sel   = MAX_ID_W'(i);
            end
        end
    end

    logic                  ram_wr_en_q, ram_rd_en_q;
    logic [ADDR_WIDTH-1:0] ram_wr_addr_q, ram_rd_addr_q;
    logic [RAM_WIDTH-1:0]  ram_wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
        end else begin
            ram_wr_en_q <= |wr_gnt;
            ram_rd_en_q <= |rd_gnt;
            if (|wr_gnt) begin
                ram_wr_addr_q <= wr_addr_sel;
                ram_wr_data_q <= wr_data_sel;
            end
            if (|rd_gnt) ram_rd_addr_q <= rd_addr_sel;
        end
    end

    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;

    // Stage 0 runs alongside ram_rd_en; stage RD_LAT lines up with ram_rd_data.
    rd_tag_t tag_q [RD_LAT+1];
    rd_tag_t tag_in, tag_s1;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = |rd_gnt;
        tag_in.id    = rd_id_sel;
        tag_s1       = tag_q[0];
`ifdef RAM_ARB_FWD_EN
        tag_s1.fwd_hit  = ram_wr_en_q && ram_rd_en_q && (ram_wr_addr_q == ram_rd_addr_q);
        tag_s1.fwd_data = MAX_DATA_W'(ram_wr_data_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            tag_q[1] <= tag_s1;
            for (int s = 2; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    rd_tag_t              tag_out;
    logic [RAM_WIDTH-1:0] ret_data, rd_hold_q;

    always_comb begin
        tag_out = tag_q[RD_LAT];
`ifdef RAM_ARB_FWD_EN
        ret_data = tag_out.fwd_hit ? tag_out.fwd_data[RAM_WIDTH-1:0] : ram_rd_data;
`else
        ret_data = ram_rd_data;
`endif
        for (int i = 0; i < NUM_REQ; i++)
            rd_valid[i] = tag_out.valid && (tag_out.id == MAX_ID_W'(i));
        rd_data_o = tag_out.valid ? ret_data : rd_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             rd_hold_q <= '0;
        else if (tag_out.valid) rd_hold_q <= ret_data;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: instance a (2 requesters, RD_LAT=1) and instance b
// (4 requesters, RD_LAT=3), each with a behavioural RAM that returns old data on collision.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a ----------------
    logic [1:0]      a_wr_req, a_rd_req, a_wr_gnt, a_rd_gnt, a_rd_valid;
    logic [1:0][8:0] a_wr_addr, a_rd_addr;
    logic [1:0][7:0] a_wr_data;
    logic [7:0]      a_rd_data, a_ram_wr_data, a_ram_rd_data;
    logic            a_ram_wr_en, a_ram_rd_en;
    logic [8:0]      a_ram_wr_addr, a_ram_rd_addr;

    ram_arbiter #(.NUM_REQ(2), .RAM_WIDTH(8), .ADDR_WIDTH(9), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_req(a_wr_req), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data), .wr_gnt(a_wr_gnt),
        .rd_req(a_rd_req), .rd_addr_i(a_rd_addr), .rd_gnt(a_rd_gnt),
        .rd_valid(a_rd_valid), .rd_data_o(a_rd_data),
        .ram_wr_en(a_ram_wr_en), .ram_wr_addr(a_ram_wr_addr), .ram_wr_data(a_ram_wr_data),
        .ram_rd_en(a_ram_rd_en), .ram_rd_addr(a_ram_rd_addr), .ram_rd_data(a_ram_rd_data)
    );

    logic [7:0] a_mem [512];
    logic [7:0] a_rp;
    always @(posedge clk) begin
        if (a_ram_wr_en) a_mem[a_ram_wr_addr] <= a_ram_wr_data;
        if (a_ram_rd_en) a_rp <= a_mem[a_ram_rd_addr];
    end
    assign a_ram_rd_data = a_rp;

    // ---------------- instance b ----------------
    logic [3:0]      b_wr_req, b_rd_req, b_wr_gnt, b_rd_gnt, b_rd_valid;
    logic [3:0][8:0] b_wr_addr, b_rd_addr;
    logic [3:0][7:0] b_wr_data;
    logic [7:0]      b_rd_data, b_ram_wr_data, b_ram_rd_data;
    logic            b_ram_wr_en, b_ram_rd_en;
    logic [8:0]      b_ram_wr_addr, b_ram_rd_addr;

    ram_arbiter #(.NUM_REQ(4), .RAM_WIDTH(8), .ADDR_WIDTH(9), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_req(b_wr_req), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data), .wr_gnt(b_wr_gnt),
        .rd_req(b_rd_req), .rd_addr_i(b_rd_addr), .rd_gnt(b_rd_gnt),
        .rd_valid(b_rd_valid), .rd_data_o(b_rd_data),
        .ram_wr_en(b_ram_wr_en), .ram_wr_addr(b_ram_wr_addr), .ram_wr_data(b_ram_wr_data),
        .ram_rd_en(b_ram_rd_en), .ram_rd_addr(b_ram_rd_addr), .ram_rd_data(b_ram_rd_data)
    );

    logic [7:0] b_mem [512];
    logic [7:0] b_rp [3];
    always @(posedge clk) begin
        if (b_ram_wr_en) b_mem[b_ram_wr_addr] <= b_ram_wr_data;
        if (b_ram_rd_en) b_rp[0] <= b_mem[b_ram_rd_addr];
        b_rp[1] <= b_rp[0];
        b_rp[2] <= b_rp[1];
    end
    assign b_ram_rd_data = b_rp[2];

`ifdef RAM_ARB_FWD_EN
    localparam logic [7:0] COLL_EXP = 8'hAA;
`else
    localparam logic [7:0] COLL_EXP = 8'h11;
`endif

    initial begin
        a_wr_req = '0; a_rd_req = '0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
        b_wr_req = '0; b_rd_req = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;

        // reset: requests present while in reset must not be granted
        step();
        a_wr_req = 2'b11;
        a_rd_req = 2'b11;
        @(negedge clk);
        chk("rst_a_wr_gnt", 32'(a_wr_gnt), 0);
        chk("rst_a_rd_gnt", 32'(a_rd_gnt), 0);
        chk("rst_a_rd_valid", 32'(a_rd_valid), 0);
        chk("rst_a_rd_data", 32'(a_rd_data), 0);
        chk("rst_a_ram_wr_en", 32'(a_ram_wr_en), 0);
        chk("rst_b_ram_rd_en", 32'(b_ram_rd_en), 0);
        step();
        rst_n = 1'b1;
        a_wr_req = '0;
        a_rd_req = '0;

        // single write by req0 then read by req1
        step();
        a_wr_req = 2'b01; a_wr_addr[0] = 9'd100; a_wr_data[0] = 8'd6;
        @(negedge clk);
        chk("w1_gnt", 32'(a_wr_gnt), 32'h1);
        step();
        a_wr_req = '0;
        @(negedge clk);
        chk("w1_ram_wr_en", 32'(a_ram_wr_en), 1);
        chk("w1_ram_wr_addr", 32'(a_ram_wr_addr), 100);
        chk("w1_ram_wr_data", 32'(a_ram_wr_data), 6);
        step();
        a_rd_req = 2'b10; a_rd_addr[1] = 9'd100;
        @(negedge clk);
        chk("r1_gnt", 32'(a_rd_gnt), 32'h2);
        chk("r1_wr_en_idle", 32'(a_ram_wr_en), 0);
        step();
        a_rd_req = '0;
        @(negedge clk);
        chk("r1_ram_rd_en", 32'(a_ram_rd_en), 1);
        chk("r1_ram_rd_addr", 32'(a_ram_rd_addr), 100);
        chk("r1_early_valid", 32'(a_rd_valid), 0);
        step();
        @(negedge clk);
        chk("r1_valid", 32'(a_rd_valid), 32'h2);
        chk("r1_data", 32'(a_rd_data), 6);
        step();
        @(negedge clk);
        chk("r1_valid_drop", 32'(a_rd_valid), 0);
        chk("r1_data_hold", 32'(a_rd_data), 6);

        // concurrent write and read on the two ports
        a_wr_req = 2'b10; a_wr_addr[1] = 9'd7; a_wr_data[1] = 8'h33;
        @(negedge clk);
        chk("c_pre_gnt", 32'(a_wr_gnt), 32'h2);
        step();
        a_wr_req = 2'b01; a_wr_addr[0] = 9'd5; a_wr_data[0] = 8'h44;
        a_rd_req = 2'b10; a_rd_addr[1] = 9'd7;
        @(negedge clk);
        chk("c_wr_gnt", 32'(a_wr_gnt), 32'h1);
        chk("c_rd_gnt", 32'(a_rd_gnt), 32'h2);
        step();
        a_wr_req = '0; a_rd_req = '0;
        @(negedge clk);
        chk("c_ram_wr_addr", 32'(a_ram_wr_addr), 5);
        chk("c_ram_rd_addr", 32'(a_ram_rd_addr), 7);
        step();
        @(negedge clk);
        chk("c_valid", 32'(a_rd_valid), 32'h2);
        chk("c_data", 32'(a_rd_data), 32'h33);

        // same-cycle write/read collision on addr 20
        step();
        a_wr_req = 2'b01; a_wr_addr[0] = 9'd20; a_wr_data[0] = 8'h11;
        step();
        a_wr_data[0] = 8'hAA;
        a_rd_req = 2'b10; a_rd_addr[1] = 9'd20;
        step();
        a_wr_req = '0; a_rd_req = '0;
        @(negedge clk);
        chk("col_both_en", 32'({a_ram_wr_en, a_ram_rd_en}), 32'h3);
        step();
        @(negedge clk);
        chk("col_valid", 32'(a_rd_valid), 32'h2);
        chk("col_data", 32'(a_rd_data), 32'(COLL_EXP));

        // reset with a read in flight
        step();
        a_rd_req = 2'b01; a_rd_addr[0] = 9'd5;
        step();
        a_rd_req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ram_rd_en", 32'(a_ram_rd_en), 0);
        chk("mrst_ram_wr_addr", 32'(a_ram_wr_addr), 0);
        chk("mrst_ram_wr_data", 32'(a_ram_wr_data), 0);
        chk("mrst_rd_data", 32'(a_rd_data), 0);
        chk("mrst_rd_valid", 32'(a_rd_valid), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst_no_valid", 32'(a_rd_valid), 0);
            step();
        end
        a_wr_req = 2'b11;
        @(negedge clk);
        chk("mrst_first_gnt", 32'(a_wr_gnt), 32'h1);
        step();
        @(negedge clk);
        chk("mrst_second_gnt", 32'(a_wr_gnt), 32'h2);
        step();
        a_wr_req = '0;

        // round-robin fairness with four requesters
        for (int i = 0; i < 4; i++) begin
            b_wr_addr[i] = 9'(10 + i);
            b_wr_data[i] = 8'(8'h50 + i);
        end
        b_wr_req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(b_wr_gnt), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_addr", 32'(b_ram_wr_addr), 32'(10 + (k - 1) % 4));
            step();
        end
        b_wr_req = '0;
        @(negedge clk);
        chk("rr_last_addr", 32'(b_ram_wr_addr), 13);
        chk("rr_last_data", 32'(b_ram_wr_data), 32'h53);

        // RD_LAT=3 back-to-back reads by requesters 0,1,0
        step();
        b_rd_req = 4'b0001; b_rd_addr[0] = 9'd10;
        @(negedge clk);
        chk("lat_gnt0", 32'(b_rd_gnt), 32'h1);
        step();
        b_rd_req = 4'b0010; b_rd_addr[1] = 9'd11;
        @(negedge clk);
        chk("lat_gnt1", 32'(b_rd_gnt), 32'h2);
        step();
        b_rd_req = 4'b0001; b_rd_addr[0] = 9'd12;
        @(negedge clk);
        chk("lat_gnt2", 32'(b_rd_gnt), 32'h1);
        step();
        b_rd_req = '0;
        @(negedge clk);
        chk("lat_n3_valid", 32'(b_rd_valid), 0);
        step();
        @(negedge clk);
        chk("lat_n4_valid", 32'(b_rd_valid), 32'h1);
        chk("lat_n4_data", 32'(b_rd_data), 32'h50);
        step();
        @(negedge clk);
        chk("lat_n5_valid", 32'(b_rd_valid), 32'h2);
        chk("lat_n5_data", 32'(b_rd_data), 32'h51);
        step();
        @(negedge clk);
        chk("lat_n6_valid", 32'(b_rd_valid), 32'h1);
        chk("lat_n6_data", 32'(b_rd_data), 32'h52);
        step();
        @(negedge clk);
        chk("lat_n7_valid", 32'(b_rd_valid), 0);
        chk("lat_n7_hold", 32'(b_rd_data), 32'h52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
